// File: rtl/alu_issue_queue_pkg.sv
// alu_issue_queue_pkg: shared opcode, instruction and FSM types for the ALU issue queue.
package alu_issue_queue_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {ADD, SUB, MUL, AND_OP, OR_OP, XOR_OP} opcode_t;

  typedef struct packed {
    opcode_t           opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Value the ALU should return; logical ops are not predicted and expect 0
  function automatic logic [DATA_W-1:0] ref_result(instruction_t i);
    return i.opcode == ADD ? i.a + i.b
         : i.opcode == SUB ? i.a - i.b
         : i.opcode == MUL ? i.a * i.b
         : '0;
  endfunction
endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: DEPTH-entry instruction FIFO with synchronous clear and occupancy count.
module issue_fifo
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  instruction_t                 wdata_i,
  output instruction_t                 rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  instruction_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  count_q;

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i) count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end

  always_ff @(posedge clock)
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;

  assign rdata_o = mem_q[rd_q];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU instructions, issues one per cycle, captures results after ALU_LATENCY.
// Define ALU_ISSUE_SCOREBOARD_EN to add the result scoreboard (mismatch, err_count).
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  instruction_t                 in_inst,
  input  logic                         flush,
  output instruction_t                 iw,
  output logic                         iw_valid,
  input  logic [31:0]                  alu_result,
  output logic                         out_valid,
  output logic [31:0]                  out_result,
  output opcode_t                      out_opcode,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
`ifdef ALU_ISSUE_SCOREBOARD_EN
  ,
  output logic                         mismatch,
  output logic [15:0]                  err_count
`endif
);
  state_t                  state_q, state_d;
  logic                    push, pop, full, empty, pipe_empty, cap;
  instruction_t            head, iw_q;
  logic                    iw_valid_q, out_valid_q;
  logic [ALU_LATENCY-1:0]  tv_q;
  opcode_t                 top_q [ALU_LATENCY];
  logic [DATA_W-1:0]       out_result_q;
  opcode_t                 out_opcode_q;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetN  (resetN),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_inst),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = flush ? FLUSH
            : state_q == FLUSH ? IDLE
            : (state_q == IDLE && push) ? RUN
            : (state_q == RUN && empty && !push && pipe_empty) ? IDLE
            : state_q;

  always_comb begin
    in_ready   = !full && state_q != FLUSH;
    busy       = state_q != IDLE;
    push       = in_valid && in_ready && !flush;
    pop        = state_q == RUN && !empty && !flush;
    pipe_empty = !iw_valid_q && tv_q == '0;
    cap        = tv_q[ALU_LATENCY-1];
  end

  // Stage 0 of the tag pipe is iw itself; tv_q holds stages 1..ALU_LATENCY
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      iw_q         <= '0;
      iw_valid_q   <= 1'b0;
      tv_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= ADD;
    end else if (flush) begin
      iw_valid_q   <= 1'b0;
      tv_q         <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      if (pop) iw_q <= head;
      iw_valid_q  <= pop;
      tv_q        <= ALU_LATENCY'({tv_q, iw_valid_q});
      out_valid_q <= cap;
      if (cap) begin
        out_result_q <= alu_result;
        out_opcode_q <= top_q[ALU_LATENCY-1];
      end
    end

  always_ff @(posedge clock) begin
    top_q[0] <= iw_q.opcode;
    for (int i = 1; i < ALU_LATENCY; i++) top_q[i] <= top_q[i-1];
  end

  assign iw         = iw_q;
  assign iw_valid   = iw_valid_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_opcode = out_opcode_q;

`ifdef ALU_ISSUE_SCOREBOARD_EN
  logic [DATA_W-1:0] exp_q [ALU_LATENCY];
  logic              mismatch_q, bad;
  logic [15:0]       err_q;

  assign bad = cap && alu_result != exp_q[ALU_LATENCY-1];

  always_ff @(posedge clock) begin
    exp_q[0] <= ref_result(iw_q);
    for (int i = 1; i < ALU_LATENCY; i++) exp_q[i] <= exp_q[i-1];
  end

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else if (flush) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      mismatch_q <= bad;
      if (bad && err_q != '1) err_q <= err_q + 1'b1;
    end

  assign mismatch  = mismatch_q;
  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed table plus randomized traffic checked against a queue-based reference model.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int L     = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  instruction_t in_inst = '0;
  logic [31:0]  alu_result = '0;
  logic         in_ready, iw_valid, out_valid, busy;
  instruction_t iw;
  logic [31:0]  out_result;
  opcode_t      out_opcode;
  logic [CW-1:0] count;
`ifdef ALU_ISSUE_SCOREBOARD_EN
  logic         mismatch;
  logic [15:0]  err_count;
`endif

  always #5 clock = ~clock;

  alu_issue_queue #(.DEPTH(DEPTH), .ALU_LATENCY(L)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .flush      (flush),
    .iw         (iw),
    .iw_valid   (iw_valid),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .count      (count),
    .busy       (busy)
`ifdef ALU_ISSUE_SCOREBOARD_EN
    ,
    .mismatch   (mismatch),
    .err_count  (err_count)
`endif
  );

  function automatic logic [31:0] alu_fn(instruction_t i);
    case (i.opcode)
      ADD:     return i.a + i.b;
      SUB:     return i.a - i.b;
      MUL:     return i.a * i.b;
      AND_OP:  return i.a & i.b;
      OR_OP:   return i.a | i.b;
      XOR_OP:  return i.a ^ i.b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] sb_ref(instruction_t i);
    case (i.opcode)
      ADD, SUB, MUL: return alu_fn(i);
      default:       return 32'd0;
    endcase
  endfunction

  function automatic instruction_t mk(opcode_t op, logic [31:0] a, logic [31:0] b);
    instruction_t r;
    r.opcode = op;
    r.a = a;
    r.b = b;
    return r;
  endfunction

  // One-cycle ALU: the word sampled on iw at one edge has its result stable before the next
  instruction_t alu_pend = '0;
  logic         corrupt = 1'b0;
  always @(posedge clock) begin
    #1;
    alu_result = alu_fn(alu_pend) - {31'b0, corrupt};
    alu_pend = iw;
  end

  typedef struct {
    int          due;
    opcode_t     op;
    logic [31:0] res;
    logic        mm;
  } fly_t;

  instruction_t mq[$];
  fly_t         mf[$];
  int           mode = 0;
  int           edge_n = 0;
  logic         e_iwv, e_ov, e_mm;
  instruction_t e_iw;
  logic [31:0]  e_res;
  opcode_t      e_op;
  logic [15:0]  e_err;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic model_reset();
    mq.delete();
    mf.delete();
    mode = 0;
    e_iwv = 1'b0;
    e_ov = 1'b0;
    e_mm = 1'b0;
    e_iw = '0;
    e_res = '0;
    e_op = ADD;
    e_err = '0;
  endtask

  // mode: 0 idle, 1 running, 2 flushing
  task automatic model_step(input logic iv, input instruction_t inst, input logic fl);
    int   pre;
    logic acc, pop, work;
    fly_t f;
    edge_n++;
    e_ov = 1'b0;
    e_mm = 1'b0;
    e_iwv = 1'b0;
    if (fl) begin
      mq.delete();
      mf.delete();
      mode = 2;
      e_err = '0;
      return;
    end
    pre  = mq.size();
    work = mf.size() > 0;
    acc  = iv && pre < DEPTH && mode != 2;
    pop  = mode == 1 && pre > 0;
    if (work && mf[0].due == edge_n) begin
      e_ov  = 1'b1;
      e_res = mf[0].res;
      e_op  = mf[0].op;
      e_mm  = mf[0].mm;
      if (e_mm && e_err != 16'hffff) e_err = e_err + 16'd1;
      void'(mf.pop_front());
    end
    if (pop) begin
      e_iw  = mq.pop_front();
      e_iwv = 1'b1;
      f.due = edge_n + L + 1;
      f.op  = e_iw.opcode;
      f.res = alu_fn(e_iw) - {31'b0, corrupt};
      f.mm  = f.res != sb_ref(e_iw);
      mf.push_back(f);
    end
    if (acc) mq.push_back(inst);
    mode = mode == 2 ? 0
         : (mode == 0 && acc) ? 1
         : (mode == 1 && pre == 0 && !acc && !work) ? 0
         : mode;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 128'(count), 128'(mq.size()));
    chk("in_ready", 128'(in_ready), 128'(mq.size() < DEPTH && mode != 2));
    chk("busy", 128'(busy), 128'(mode != 0));
    chk("iw_valid", 128'(iw_valid), 128'(e_iwv));
    chk("iw", 128'(iw), 128'(e_iw));
    chk("out_valid", 128'(out_valid), 128'(e_ov));
    chk("out_result", 128'(out_result), 128'(e_res));
    chk("out_opcode", 128'(out_opcode), 128'(e_op));
`ifdef ALU_ISSUE_SCOREBOARD_EN
    chk("mismatch", 128'(mismatch), 128'(e_mm));
    chk("err_count", 128'(err_count), 128'(e_err));
`endif
  endtask

  task automatic cycle(input logic iv, input instruction_t inst, input logic fl);
    in_valid = iv;
    in_inst  = inst;
    flush    = fl;
    model_step(iv, inst, fl);
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  typedef struct {
    int          iv;
    opcode_t     op;
    int unsigned a, b;
    int          fl, cnt, rdy, iwv, ov;
    int unsigned res;
    int          bsy;
  } vec_t;

  vec_t vt[21];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt = '{
      '{1, ADD,    10, 15, 0, 1, 1, 0, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 1, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 1, 25, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 0,  0, 0},
      '{1, ADD,    10, 15, 0, 1, 1, 0, 0,  0, 1},
      '{1, SUB,    20,  5, 0, 1, 1, 1, 0,  0, 1},
      '{1, MUL,     3,  4, 0, 1, 1, 1, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 1, 1, 25, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 1, 15, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 1, 12, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 0,  0, 0},
      '{1, ADD,     7,  7, 0, 1, 1, 0, 0,  0, 1},
      '{1, SUB,     9,  2, 0, 1, 1, 1, 0,  0, 1},
      '{1, XOR_OP,  5,  5, 1, 0, 0, 0, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 0,  0, 0},
      '{1, ADD,     1,  1, 0, 1, 1, 0, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 1, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 0,  0, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 1,  2, 1},
      '{0, ADD,     0,  0, 0, 0, 1, 0, 0,  0, 0}
    };

    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    resetN = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cycle(vt[i].iv != 0, mk(vt[i].op, vt[i].a, vt[i].b), vt[i].fl != 0);
      chk($sformatf("row%0d count", i), 128'(count), 128'(vt[i].cnt));
      chk($sformatf("row%0d in_ready", i), 128'(in_ready), 128'(vt[i].rdy));
      chk($sformatf("row%0d iw_valid", i), 128'(iw_valid), 128'(vt[i].iwv));
      chk($sformatf("row%0d out_valid", i), 128'(out_valid), 128'(vt[i].ov));
      chk($sformatf("row%0d busy", i), 128'(busy), 128'(vt[i].bsy));
      if (vt[i].ov != 0) chk($sformatf("row%0d out_result", i), 128'(out_result), 128'(vt[i].res));
    end

    // Five consecutive pushes out of a flush-recovered idle
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, mk(opcode_t'(k % 3), 32'(100 + k), 32'(k)), 1'b0);
      chk("count_le_depth", 128'(count <= CW'(DEPTH)), 128'(1));
    end
    repeat (6) cycle(1'b0, '0, 1'b0);

    // Asynchronous reset in the middle of traffic
    cycle(1'b1, mk(ADD, 32'd3, 32'd4), 1'b0);
    cycle(1'b1, mk(SUB, 32'd8, 32'd1), 1'b0);
    in_valid = 1'b0;
    #2 resetN = 1'b0;
    #1 model_reset();
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst iw_valid", 128'(iw_valid), 128'(0));
    chk("rst count", 128'(count), 128'(0));
    chk("rst in_ready", 128'(in_ready), 128'(1));
    check_all();
    @(negedge clock);
    resetN = 1'b1;
    repeat (2) cycle(1'b0, '0, 1'b0);

`ifdef ALU_ISSUE_SCOREBOARD_EN
    corrupt = 1'b1;
    cycle(1'b1, mk(ADD, 32'd10, 32'd15), 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    corrupt = 1'b0;
    chk("sb err_count", 128'(err_count), 128'(1));
    cycle(1'b1, mk(ADD, 32'd10, 32'd15), 1'b0);
    repeat (3) begin
      cycle(1'b0, '0, 1'b0);
      chk("sb mismatch_clean", 128'(mismatch), 128'(0));
    end
`endif

    repeat (400)
      cycle($urandom_range(0, 9) < 7,
            mk(opcode_t'($urandom_range(0, 5)), $urandom, $urandom),
            $urandom_range(0, 49) == 0);
    repeat (6) cycle(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
